// File: rtl/vga_scanout.sv
// VGA read-side engine: 640x480@60 timing from CPUclk, fetches monochrome screen
// words from the RAM pixel port and shifts them out LSB-first on a 1-bit video line.
module vga_scanout #(
    parameter int WIDTH    = 16,
    parameter int CLK_DIV  = 2,
    parameter int SCREEN_W = 512,
    parameter int SCREEN_H = 256,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             CPUclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pixel_word,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] SCR_W  = 10'(SCREEN_W);
    localparam logic [9:0] SCR_H  = 10'(SCREEN_H);
    localparam logic [9:0] WORD   = 10'(WIDTH);

    logic [DW-1:0]    div;
    logic [9:0]       h;
    logic [9:0]       v;
    logic [WIDTH-1:0] shreg;

    logic             pix_en;
    logic             scr;
    logic             word_start;
    logic             last_word;
    logic [10:0]      next_x;
    logic [9:0]       next_y;

    always_comb begin
        pix_en     = (div == DIV_LAST);
        scr        = (h < SCR_W) && (v < SCR_H);
        word_start = ((h % WORD) == 10'd0);
        // One extra bit so h+WIDTH cannot wrap when the screen spans the full line.
        next_x     = {1'b0, h} + {1'b0, WORD};
        last_word  = (next_x >= {1'b0, SCR_W});
        next_y     = (v + 10'd1 == SCR_H) ? 10'd0 : v + 10'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // below sees the pre-increment h and v regardless of statement order.
    always_ff @(posedge CPUclk) begin
        if (rst) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            shreg       <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_en ? '0 : div + DW'(1);
            frame_start <= pix_en && (h == 10'd0) && (v == 10'd0);
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
                hsync <= !((h >= HS_BEG) && (h < HS_END));
                vsync <= !((v >= VS_BEG) && (v < VS_END));

                if (scr && word_start) begin
                    video <= pixel_word[0];
                    shreg <= pixel_word >> 1;
                    if (last_word) begin
                        pixel_x <= '0;
                        pixel_y <= next_y;
                    end else begin
                        pixel_x <= next_x[9:0];
                    end
                end else if (scr) begin
                    video <= shreg[0];
                    shreg <= shreg >> 1;
                end else begin
                    video <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (64x13 total, 32x4 screen),
// plus a second instance whose screen spans the full visible line.
module tb_vga_scanout;

    localparam int WIDTH   = 16;
    localparam int H_TOTAL = 64;
    localparam int FRAME   = 2 * H_TOTAL * 13;   // 1664 clocks

    logic        CPUclk = 1'b0;
    logic        rst    = 1'b1;
    logic [15:0] word_a, word_b;
    logic [9:0]  px_a, py_a, px_b, py_b;
    logic        hs_a, vs_a, vid_a, fs_a;
    logic        hs_b, vs_b, vid_b, fs_b;

    int mode = 1;
    int fclk = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int m_hs_low, m_vs_low, m_hs_line0, m_first_hs, m_first_vs;
    int m_lit_a, m_lit_b, m_first_lit, m_fs, m_last_chg, m_first_chg;
    int log_a[16];
    int log_b[16];
    int n_log_a, n_log_b;

    always #5 CPUclk = ~CPUclk;

    vga_scanout #(
        .WIDTH(16), .CLK_DIV(2), .SCREEN_W(32), .SCREEN_H(4),
        .H_VIS(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_dut (
        .CPUclk(CPUclk), .rst(rst), .pixel_word(word_a),
        .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
        .video(vid_a), .frame_start(fs_a)
    );

    vga_scanout #(
        .WIDTH(16), .CLK_DIV(2), .SCREEN_W(48), .SCREEN_H(4),
        .H_VIS(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_full (
        .CPUclk(CPUclk), .rst(rst), .pixel_word(word_b),
        .pixel_x(px_b), .pixel_y(py_b), .hsync(hs_b), .vsync(vs_b),
        .video(vid_b), .frame_start(fs_b)
    );

    // Screen contents for each test mode; the RAM answers one clock after the address.
    function automatic logic [15:0] ram_word(int m, logic [9:0] x, logic [9:0] y);
        case (m)
            0:       return (x == 10'd0 && y == 10'd0) ? 16'h0001 : 16'h0000;
            1:       return 16'hFFFF;
            default: return (x == 10'd0) ? 16'h00F0 : ((x == 10'd16) ? 16'h8001 : 16'h0000);
        endcase
    endfunction

    always @(posedge CPUclk) begin
        word_a <= ram_word(mode, px_a, py_a);
        word_b <= ram_word(mode, px_b, py_b);
    end

    // Clocks since the last frame_start; output pixel n is visible while fclk is 2n or 2n+1.
    always @(posedge CPUclk) begin
        #1;
        if (fs_a) fclk = 0;
        else      fclk = fclk + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_fclk(input int target);
        bit found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge CPUclk);
            if (fclk == target) found = 1;
        end
        if (!found) check($sformatf("timeout_fclk_%0d", target), 0, 1);
    endtask

    task automatic count_to_frame_start(input string name, input int expected);
        int cnt = 0;
        bit seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge CPUclk);
            cnt++;
            if (fs_a) seen = 1;
        end
        check(name, seen ? cnt : -1, expected);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hsync"},       int'(hs_a),  1);
        check({tag, "_vsync"},       int'(vs_a),  1);
        check({tag, "_video"},       int'(vid_a), 0);
        check({tag, "_frame_start"}, int'(fs_a),  0);
        check({tag, "_pixel_x"},     int'(px_a),  0);
        check({tag, "_pixel_y"},     int'(py_a),  0);
        check({tag, "_full_pixel_y"}, int'(py_b), 0);
    endtask

    task automatic measure_frame();
        logic [9:0] pxa, pya, pxb, pyb;
        wait_fclk(FRAME - 1);
        m_hs_low = 0; m_vs_low = 0; m_hs_line0 = 0; m_first_hs = -1; m_first_vs = -1;
        m_lit_a = 0; m_lit_b = 0; m_first_lit = -1; m_fs = 0; m_last_chg = -1; m_first_chg = -1;
        n_log_a = 0; n_log_b = 0;
        pxa = px_a; pya = py_a; pxb = px_b; pyb = py_b;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CPUclk);
            if (!hs_a) begin
                m_hs_low++;
                if (m_first_hs < 0) m_first_hs = i;
                if (i < 2 * H_TOTAL) m_hs_line0++;
            end
            if (!vs_a) begin
                m_vs_low++;
                if (m_first_vs < 0) m_first_vs = i;
            end
            if (vid_a) begin
                m_lit_a++;
                if (m_first_lit < 0) m_first_lit = i;
            end
            if (vid_b) m_lit_b++;
            if (fs_a) m_fs++;
            if (px_a != pxa || py_a != pya) begin
                if (n_log_a < 16) log_a[n_log_a] = int'(px_a) * 1024 + int'(py_a);
                n_log_a++;
                if (m_first_chg < 0) m_first_chg = i;
                m_last_chg = i;
                pxa = px_a; pya = py_a;
            end
            if (px_b != pxb || py_b != pyb) begin
                if (n_log_b < 16) log_b[n_log_b] = int'(px_b) * 1024 + int'(py_b);
                n_log_b++;
                pxb = px_b; pyb = py_b;
            end
        end
    endtask

    typedef struct {
        int   mode;
        int   h;
        int   v;
        logic vid;
        logic hs;
        logic vs;
    } vec_t;

    vec_t vecs[21];
    int   exp_a[8];
    int   exp_b[12];

    initial begin
        // mode 1: all-white RAM
        vecs[0]  = '{1,  0,  0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1, 32,  0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1, 31,  3, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1,  0,  4, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1, 51,  5, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1, 52,  5, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1, 59,  5, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1, 60,  5, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1, 10,  9, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1, 63, 10, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1,  0, 11, 1'b0, 1'b1, 1'b1};
        // mode 0: single lit pixel at the top-left corner
        vecs[11] = '{0,  0,  0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{0,  1,  0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{0,  0,  1, 1'b0, 1'b1, 1'b1};
        // mode 2: 00F0 in word 0, 8001 in word 1 of every line
        vecs[14] = '{2, 16,  0, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{2, 17,  0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{2,  3,  2, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{2,  4,  2, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{2,  7,  2, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{2,  8,  2, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{2, 31,  3, 1'b1, 1'b1, 1'b1};

        // fetch pointer after each load, encoded x*1024+y
        exp_a = '{16384, 1, 16385, 2, 16386, 3, 16387, 0};
        exp_b = '{16384, 32768, 1, 16385, 32769, 2, 16386, 32770, 3, 16387, 32771, 0};

        repeat (3) @(negedge CPUclk);
        check_reset_values("reset");
        rst = 1'b0;
        count_to_frame_start("first_frame_start_clocks", 2);
        count_to_frame_start("frame_period", FRAME);

        measure_frame();
        check("hsync_low_clocks_frame", m_hs_low, 13 * 16);
        check("hsync_low_clocks_line0", m_hs_line0, 16);
        check("hsync_first_low", m_first_hs, 2 * 52);
        check("vsync_low_clocks", m_vs_low, 2 * 2 * H_TOTAL);
        check("vsync_first_low", m_first_vs, 2 * 9 * H_TOTAL);
        check("lit_clocks_white", m_lit_a, 2 * 32 * 4);
        check("lit_clocks_white_full", m_lit_b, 2 * 48 * 4);
        check("frame_start_pulses", m_fs, 1);
        check("first_fetch_change", m_first_chg, 0);
        check("last_fetch_change", m_last_chg, 2 * (3 * H_TOTAL + 16));
        check("loads_per_frame", n_log_a, 8);
        check("loads_per_frame_full", n_log_b, 12);
        for (int i = 0; i < 8; i++)  check($sformatf("fetch_seq_%0d", i), log_a[i], exp_a[i]);
        for (int i = 0; i < 12; i++) check($sformatf("fetch_seq_full_%0d", i), log_b[i], exp_b[i]);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].mode != mode) begin
                mode = vecs[i].mode;
                wait_fclk(10);
                wait_fclk(0);
            end
            wait_fclk(2 * (vecs[i].v * H_TOTAL + vecs[i].h));
            check($sformatf("vec%0d_video", i), int'(vid_a), int'(vecs[i].vid));
            check($sformatf("vec%0d_hsync", i), int'(hs_a),  int'(vecs[i].hs));
            check($sformatf("vec%0d_vsync", i), int'(vs_a),  int'(vecs[i].vs));
        end

        mode = 0;
        wait_fclk(10);
        measure_frame();
        check("lit_clocks_single", m_lit_a, 2);
        check("lit_first_single", m_first_lit, 0);

        // Reset pulse in the middle of a lit screen word.
        mode = 1;
        wait_fclk(10);
        wait_fclk(0);
        wait_fclk(2 * (2 * H_TOTAL + 30));
        check("pre_reset_video", int'(vid_a), 1);
        check("pre_reset_pixel_x", int'(px_a), 0);
        check("pre_reset_pixel_y", int'(py_a), 3);
        check("pre_reset_full_pixel_x", int'(px_b), 32);
        rst = 1'b1;
        @(negedge CPUclk);
        check_reset_values("midframe_reset");
        rst = 1'b0;
        count_to_frame_start("post_reset_frame_start_clocks", 2);
        check("post_reset_first_video", int'(vid_a), 1);
        count_to_frame_start("post_reset_frame_period", FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Video read-side engine: generates 640x480@60 VGA timing from CPUclk and fetches monochrome screen words from the RAM's pixel read port.
- Drives pixel_x/pixel_y to the RAM, receives pixel_out one clock later, and serializes each word onto a 1-bit video output.
- The SCREEN_W x SCREEN_H screen is displayed at the top-left of the 640x480 raster; the rest of the raster is black.

Parameters:
- WIDTH, 16, bits per screen word (pixels per word).
- CLK_DIV, 2, CPUclk cycles per pixel (50MHz -> 25MHz); must be >= 2.
- SCREEN_W, 512, displayed screen width in pixels; a multiple of WIDTH, <= 640.
- SCREEN_H, 256, displayed screen height in lines, <= 480.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- CPUclk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pixel_word  in  WIDTH  screen word returned by RAM for the previous clock's pixel_x/pixel_y
- pixel_x  out  10  x coordinate of the first pixel of the word to fetch
- pixel_y  out  10  line of the word to fetch
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video  out  1  pixel value: 1 = white, 0 = black
- frame_start  out  1  one-clock pulse on the pix_en cycle where h=0 and v=0

Behaviour:
Interface:
- One clock (CPUclk); reset is synchronous and active-high (rst).
- All outputs are registered.

Reset values:
- div=0, h=0, v=0, shreg=0.
- pixel_x=0, pixel_y=0.
- hsync=1, vsync=1, video=0, frame_start=0.
- Reset asserted mid-frame or mid-word aborts the frame immediately; the first pixel after reset release is h=0, v=0.

Divider:
- div counts 0..CLK_DIV-1 and wraps.
- pix_en = (div==CLK_DIV-1).
- Nothing other than div changes on cycles without pix_en.

Counters:
- On pix_en, h increments; at H_TOTAL-1 (800-1) h wraps to 0 and v increments.
- v wraps to 0 at V_TOTAL-1 (525-1).
- h and v are each 10 bits.

Outputs on pix_en, computed from the pre-increment h and v:
- hsync = 0 iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491).
- frame_start = 1 iff h==0 and v==0; otherwise it is 0 on every cycle.
- scr = (h < SCREEN_W) && (v < SCREEN_H).
- If scr and h%WIDTH==0: video <= pixel_word[0] and shreg <= pixel_word>>1.
- Else if scr: video <= shreg[0] and shreg <= shreg>>1.
- Else: video <= 0.
- Pixel order is LSB = leftmost pixel.

Fetch:
- On pix_en with scr and h%WIDTH==0, the fetch pointer advances:
  - If h+WIDTH < SCREEN_W: pixel_x <= h+WIDTH; pixel_y unchanged.
  - Otherwise (last word of the line): pixel_x <= 0, and pixel_y <= v+1, or 0 when v+1==SCREEN_H.
- pixel_x/pixel_y therefore hold the next word's coordinates for WIDTH*CLK_DIV clocks before that word is loaded.
- The RAM's 1-clock read latency is satisfied with margin. pixel_word is sampled only at a load.

Boundaries:
- No loads occur for lines >= SCREEN_H.
- After the last screen word of a frame, pixel_x=0 and pixel_y=0 hold until word (0,0) of the next frame loads.
- SCREEN_W == H_VIS must work: the fetch wraps on the last visible word.

Test Plan:
- Reset release, no further stimulus -> first pix_en at clock 2; line period exactly 1600 clocks; frame period exactly 840000 clocks; frame_start pulses once per frame.
- Count hsync over one line -> low for exactly 96 pixel periods (192 clocks), starting at h=656; count vsync over one frame -> low for exactly 2 lines (3200 clocks), starting at v=490.
- RAM model returns 16'h0001 for word (0,0) and 0 elsewhere -> video=1 for exactly the first pixel (2 clocks) of line 0 and 0 for the rest of the frame.
- RAM model returns 16'hFFFF everywhere -> video=1 for h<512 and v<256 only; total lit pixels per frame = 131072.
- Trace pixel_x/pixel_y -> sequence (16,0),(32,0)...(496,0),(0,1) within line 0; after line 255, (0,0) holds through the blanking lines; pixel_word is sampled exactly 32 times per screen line.
- rst asserted for 1 clock at h=300, v=100 -> the next clock shows all reset values; the following frame has the correct timing from h=0, v=0.
